// File: rtl/ball_physics_engine.sv
`default_nettype none
// ball_physics_engine: steps one ball a cell at a time against NUM_BARS bars, walls and target.
// Rev 1.0. Optional build macro BOUNCE_COUNT_EN adds a saturating bounce_count output.
module ball_physics_engine #(
  parameter int XW        = 8,
  parameter int YW        = 7,
  parameter int NUM_BARS  = 5,
  parameter int BAR_LEN   = 3,
  parameter int SCREEN_W  = 160,
  parameter int SCREEN_H  = 120,
  parameter int TARGET_X  = 156,
  parameter int TARGET_Y0 = 56,
  parameter int TARGET_Y1 = 62
) (
  input  logic                             clock,
  input  logic                             reset,
  input  logic                             start,
  input  logic [XW-1:0]                    start_x,
  input  logic [YW-1:0]                    start_y,
  input  logic                             start_vx,
  input  logic                             start_vy,
  input  logic                             step,
  input  logic [NUM_BARS*(1+XW+YW)-1:0]    bars,
  output logic                             busy,
  output logic [XW-1:0]                    xpos,
  output logic [YW-1:0]                    ypos,
  output logic                             draw_valid,
  input  logic                             draw_ready,
  output logic                             win,
  output logic                             lose
`ifdef BOUNCE_COUNT_EN
  ,output logic [7:0]                      bounce_count
`endif
);
  localparam int BW = 1 + XW + YW;
  localparam logic [XW:0] X_MAX    = (XW+1)'(SCREEN_W - 1);
  localparam logic [YW:0] Y_MAX    = (YW+1)'(SCREEN_H - 1);
  localparam logic [XW:0] TX       = (XW+1)'(TARGET_X);
  localparam logic [YW:0] TY0      = (YW+1)'(TARGET_Y0);
  localparam logic [YW:0] TY1      = (YW+1)'(TARGET_Y1);
  localparam logic [3:0]  LAST_IDX = 4'(NUM_BARS - 1);

  typedef enum logic [2:0] {IDLE, SCAN, WALL, MOVE, DRAW, DONE} state_t;

  state_t                  state_q, state_d;
  logic [XW-1:0]           x_q, x_d;
  logic [YW-1:0]           y_q, y_d;
  logic                    vx_q, vx_d, vy_q, vy_d;
  logic                    flip_x_q, flip_x_d, flip_y_q, flip_y_d;
  logic [3:0]              idx_q, idx_d;
  logic [NUM_BARS*BW-1:0]  bars_q, bars_d;
  logic                    busy_q, busy_d, draw_valid_q, draw_valid_d;
  logic                    win_q, win_d, lose_q, lose_d;
`ifdef BOUNCE_COUNT_EN
  logic [7:0]              bcnt_q, bcnt_d;
`endif

  logic [XW:0] nx, cand_x;
  logic [YW:0] ny, cand_y;
  logic [XW-1:0] new_x;
  logic [YW-1:0] new_y;
  logic [BW-1:0] bar_sel;
  logic hit_x, hit_y, hit_c, vx_new, vy_new, hit_target;

  // Widened coordinates: x-1 at 0 becomes a huge value that can never match a bar cell.
  function automatic logic occupied(input logic [BW-1:0] bar, input logic [XW:0] cx,
                                    input logic [YW:0] cy);
    logic [XW+1:0] bx, cxe;
    logic [YW+1:0] by, cye;
    bx  = {2'b00, bar[XW:1]};
    by  = {2'b00, bar[XW+YW:XW+1]};
    cxe = {1'b0, cx};
    cye = {1'b0, cy};
    if (bar[0])
      return (cxe == bx) && (cye >= by) && (cye < by + (YW+2)'(BAR_LEN));
    return (cye == by) && (cxe >= bx) && (cxe < bx + (XW+2)'(BAR_LEN));
  endfunction

  function automatic logic any_bar(input logic [NUM_BARS*BW-1:0] bv, input logic [XW:0] cx,
                                   input logic [YW:0] cy);
    logic hit;
    hit = 1'b0;
    for (int i = 0; i < NUM_BARS; i++)
      if (occupied(bv[i*BW +: BW], cx, cy)) hit = 1'b1;
    return hit;
  endfunction

  assign nx = vx_q ? ({1'b0, x_q} + 1'b1) : ({1'b0, x_q} - 1'b1);
  assign ny = vy_q ? ({1'b0, y_q} + 1'b1) : ({1'b0, y_q} - 1'b1);

  always_comb begin
    bar_sel = '0;
    for (int i = 0; i < NUM_BARS; i++)
      if (idx_q == 4'(i)) bar_sel = bars_q[i*BW +: BW];
    hit_x = occupied(bar_sel, nx, {1'b0, y_q});
    hit_y = occupied(bar_sel, {1'b0, x_q}, ny);
    hit_c = occupied(bar_sel, nx, ny);
  end

  // Each axis is resolved independently; a blocked axis keeps its coordinate this step.
  always_comb begin
    vx_new = vx_q ^ flip_x_q;
    vy_new = vy_q ^ flip_y_q;
    cand_x = vx_new ? ({1'b0, x_q} + 1'b1) : ({1'b0, x_q} - 1'b1);
    cand_y = vy_new ? ({1'b0, y_q} + 1'b1) : ({1'b0, y_q} - 1'b1);
    new_x  = x_q;
    new_y  = y_q;
    if (cand_x <= X_MAX && !any_bar(bars_q, cand_x, {1'b0, y_q})) new_x = cand_x[XW-1:0];
    if (cand_y <= Y_MAX && !any_bar(bars_q, {1'b0, x_q}, cand_y)) new_y = cand_y[YW-1:0];
    hit_target = ({1'b0, new_x} >= TX) && ({1'b0, new_y} >= TY0) && ({1'b0, new_y} <= TY1);
  end

  always_comb begin
    state_d      = state_q;
    x_d          = x_q;
    y_d          = y_q;
    vx_d         = vx_q;
    vy_d         = vy_q;
    flip_x_d     = flip_x_q;
    flip_y_d     = flip_y_q;
    idx_d        = idx_q;
    bars_d       = bars_q;
    busy_d       = busy_q;
    draw_valid_d = draw_valid_q;
    win_d        = win_q;
    lose_d       = lose_q;
`ifdef BOUNCE_COUNT_EN
    bcnt_d       = bcnt_q;
`endif
    case (state_q)
      IDLE: if (step && !win_q && !lose_q) begin
        bars_d   = bars;
        flip_x_d = 1'b0;
        flip_y_d = 1'b0;
        idx_d    = 4'd0;
        busy_d   = 1'b1;
        state_d  = SCAN;
      end
      SCAN: begin
        if (hit_x) flip_x_d = 1'b1;
        if (hit_y) flip_y_d = 1'b1;
        if (!hit_x && !hit_y && hit_c) begin
          flip_x_d = 1'b1;
          flip_y_d = 1'b1;
        end
        idx_d   = idx_q + 4'd1;
        state_d = (idx_q == LAST_IDX) ? WALL : SCAN;
      end
      WALL: begin
        if ((y_q == '0 && !vy_q) || ({1'b0, y_q} == Y_MAX && vy_q)) flip_y_d = 1'b1;
        if ({1'b0, x_q} == X_MAX && vx_q) flip_x_d = 1'b1;
        if (x_q == '0 && !vx_q) begin
          lose_d  = 1'b1;
          busy_d  = 1'b0;
          state_d = DONE;
        end else begin
          state_d = MOVE;
        end
      end
      MOVE: begin
        vx_d         = vx_new;
        vy_d         = vy_new;
        x_d          = new_x;
        y_d          = new_y;
        win_d        = win_q | hit_target;
        draw_valid_d = 1'b1;
        state_d      = DRAW;
`ifdef BOUNCE_COUNT_EN
        if ((flip_x_q || flip_y_q) && bcnt_q != 8'hFF) bcnt_d = bcnt_q + 8'd1;
`endif
      end
      DRAW: if (draw_valid_q && draw_ready) begin
        draw_valid_d = 1'b0;
        busy_d       = 1'b0;
        state_d      = win_q ? DONE : IDLE;
      end
      DONE:    state_d = DONE;
      default: state_d = IDLE;
    endcase
    // start overrides whatever the current state decided.
    if (start) begin
      x_d          = start_x;
      y_d          = start_y;
      vx_d         = start_vx;
      vy_d         = start_vy;
      win_d        = 1'b0;
      lose_d       = 1'b0;
      flip_x_d     = 1'b0;
      flip_y_d     = 1'b0;
      draw_valid_d = 1'b1;
      state_d      = DRAW;
`ifdef BOUNCE_COUNT_EN
      bcnt_d       = 8'd0;
`endif
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q      <= IDLE;
      x_q          <= '0;
      y_q          <= '0;
      vx_q         <= 1'b0;
      vy_q         <= 1'b0;
      flip_x_q     <= 1'b0;
      flip_y_q     <= 1'b0;
      idx_q        <= 4'd0;
      bars_q       <= '0;
      busy_q       <= 1'b0;
      draw_valid_q <= 1'b0;
      win_q        <= 1'b0;
      lose_q       <= 1'b0;
`ifdef BOUNCE_COUNT_EN
      bcnt_q       <= 8'd0;
`endif
    end else begin
      state_q      <= state_d;
      x_q          <= x_d;
      y_q          <= y_d;
      vx_q         <= vx_d;
      vy_q         <= vy_d;
      flip_x_q     <= flip_x_d;
      flip_y_q     <= flip_y_d;
      idx_q        <= idx_d;
      bars_q       <= bars_d;
      busy_q       <= busy_d;
      draw_valid_q <= draw_valid_d;
      win_q        <= win_d;
      lose_q       <= lose_d;
`ifdef BOUNCE_COUNT_EN
      bcnt_q       <= bcnt_d;
`endif
    end
  end

  assign busy       = busy_q;
  assign xpos       = x_q;
  assign ypos       = y_q;
  assign draw_valid = draw_valid_q;
  assign win        = win_q;
  assign lose       = lose_q;
`ifdef BOUNCE_COUNT_EN
  assign bounce_count = bcnt_q;
`endif

endmodule
`default_nettype wire

// File: doc/ball_physics_engine.md
Name: ball_physics_engine

Overview:
- Parametrised successor to the single-bar ball collision logic.
- Advances one ball by one cell per accepted step and sequentially checks NUM_BARS obstacle bars, one per cycle.
- Applies wall, bar-side and bar-corner bounces, then detects win (target region) and lose (left edge).
- Presents the new ball position to the VGA writer through a valid/ready handshake.
- Sits between the game controller (start/step/win/lose) and the VGA draw path.

Parameters:
XW, 8, x coordinate width
YW, 7, y coordinate width
NUM_BARS, 5, number of obstacle bars (1..16)
BAR_LEN, 3, bar length in cells
SCREEN_W, 160, playfield width; x valid 0..SCREEN_W-1
SCREEN_H, 120, playfield height; y valid 0..SCREEN_H-1
TARGET_X, 156, win when x >= TARGET_X ...
TARGET_Y0, 56, ... and y >= TARGET_Y0 ...
TARGET_Y1, 62, ... and y <= TARGET_Y1

Ports:
clock  in  1  system clock, rising edge
reset  in  1  asynchronous, active-low reset
start  in  1  pulse: load start state, clear win/lose
start_x  in  XW  initial x
start_y  in  YW  initial y
start_vx  in  1  initial x direction (1 = +x, 0 = -x)
start_vy  in  1  initial y direction (1 = +y/down, 0 = -y/up)
step  in  1  pulse: advance ball one cell
bars  in  NUM_BARS*(1+XW+YW)  packed bars; bar i at [i*BW +: BW], BW=1+XW+YW; bit0 = vertical(1)/horizontal(0), bits[XW:1] = x, bits[XW+YW:XW+1] = y (top/left cell)
busy  out  1  step in progress; step ignored while high
xpos  out  XW  current ball x
ypos  out  YW  current ball y
draw_valid  out  1  xpos/ypos ready for VGA
draw_ready  in  1  VGA accepts position
win  out  1  sticky win
lose  out  1  sticky lose

Behaviour:
- Reset (reset=0, asynchronous): state IDLE; xpos=0, ypos=0, vx=0, vy=0; busy, draw_valid, win, lose all 0; bar latch cleared.
- Bar geometry: vertical bar occupies (x, y..y+BAR_LEN-1); horizontal bar occupies (x..x+BAR_LEN-1, y).
- Coordinate arithmetic uses XW+1 / YW+1 bits so x-1 at 0 and y+BAR_LEN never alias.
- start has priority over all other inputs in any state, including mid-step or mid-draw:
  - Loads start_x/y/vx/vy, clears win/lose, clears pending flip flags.
  - Next state is DRAW, which presents the initial position.
- FSM states: IDLE, SCAN, WALL, MOVE, DRAW, DONE.
- IDLE:
  - step=1 while win=lose=0: latch bars, clear flip_x/flip_y, idx=0, busy=1, go to SCAN.
  - step in any other state, or once win or lose is set, is ignored.
- SCAN: one cycle per bar, idx 0..NUM_BARS-1. Let nx=x±1 and ny=y±1, per direction.
  - (nx,y) occupied -> flip_x.
  - (x,ny) occupied -> flip_y.
  - Neither, but (nx,ny) occupied -> flip_x and flip_y (corner).
  - Flags OR-accumulate across bars. After the last idx, go to WALL. SCAN lasts exactly NUM_BARS cycles.
- WALL (1 cycle):
  - y=0 with vy=0, or y=SCREEN_H-1 with vy=1 -> flip_y.
  - x=SCREEN_W-1 with vx=1 -> flip_x.
  - x=0 with vx=0 -> lose=1, busy=0, go to DONE; position is unchanged and no draw occurs.
  - Otherwise go to MOVE.
- MOVE (1 cycle):
  - Toggle vx/vy for each set flip flag.
  - Update x by the new vx and y by the new vy.
  - An axis whose new step would leave the screen or enter a latched bar cell holds position for this step; its velocity is still flipped.
  - Then evaluate the target on the updated position; a hit sets win=1.
  - Go to DRAW.
- DRAW:
  - draw_valid=1 with xpos/ypos stable.
  - On draw_valid & draw_ready: draw_valid=0, busy=0.
  - Go to DONE if win=1, else IDLE.
- DONE: holds until start or reset.
- Step latency with draw_ready tied high: NUM_BARS+3 cycles from step to draw_valid falling.

Optional Feature:
- Macro BOUNCE_COUNT_EN.
- When defined:
  - Adds output bounce_count [7:0].
  - Increments by 1 in MOVE when flip_x or flip_y is set (a double flip counts once).
  - Saturates at 255; clears on reset and on start.
- When undefined: no port and no counter logic.

Test Plan:
- Free flight: start (10,10) vx=1 vy=1, no bar in reach, step -> draw_valid with (11,11); busy high for NUM_BARS+3 cycles.
- Vertical bar side hit: bar0 vertical at (12,9), ball (11,10) vx=1, step -> vx=0, ball moves to x=10, y=11.
- Corner hit: horizontal bar at (12,12), ball (11,11) vx=1 vy=1 -> both flip, ball moves to (10,10).
- Wall: ball (50,0) vy=0 -> vy=1, y=1. Separately, ball (0,30) vx=0 -> lose=1, no draw_valid, later steps ignored.
- Win: ball (155,58) vx=1 -> (156,59 or 57), win=1, state DONE. Hold draw_ready=0 for 5 cycles: xpos/ypos and draw_valid stay stable.
- Reset and abort: start asserted during SCAN reloads state and draws the start position. Asserting reset low mid-DRAW clears all outputs immediately, without waiting for a clock edge.
